// File: rtl/pri_enc16_4.sv
// 16-line rising-edge event capture with a highest-index-first
// priority grant and acknowledge handshake.
module pri_enc16_4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        en,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pend,
  output logic        any,
  output logic        ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_req_q;
  logic [15:0] r_pend;
  logic [3:0]  r_code;
  logic        r_ovf;

  logic [15:0] w_rise;
  logic [15:0] w_set;
  logic [15:0] w_clr;
  logic [15:0] w_pend_nx;
  logic        w_ovf_nx;
  logic [3:0]  w_hi;
  logic [3:0]  w_code_nx;

  assign w_rise    = req & ~r_req_q;
  assign w_set     = w_rise & {16{en}};
  assign w_clr     = (r_state == GRANT && ack)
                   ? (16'h0001 << r_code) : 16'h0000;
  // set wins over clear on the same bit
  assign w_pend_nx = (r_pend & ~w_clr) | w_set;
  assign w_ovf_nx  = |(w_set & r_pend & ~w_clr);

  always_comb begin
    w_hi = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_pend[i]) w_hi = 4'(i);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_code;
    unique case (r_state)
      IDLE: begin
        if (en && (r_pend != 16'h0000)) begin
          w_state_nx = GRANT;
          w_code_nx  = w_hi;
        end
      end
      GRANT: begin
        if (ack) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req_q <= 16'h0000;
      r_pend  <= 16'h0000;
      r_code  <= 4'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_req_q <= req;
      r_pend  <= w_pend_nx;
      r_code  <= w_code_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  assign code  = r_code;
  assign valid = (r_state == GRANT);
  assign pend  = r_pend;
  assign any   = |r_pend;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_pri_enc16_4.sv
// Directed bench for pri_enc16_4: array-based event/grant model
// checked every cycle plus hand-computed literal expectations.
module tb_pri_enc16_4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = 16'h0000;
  logic        en = 1'b0;
  logic        ack = 1'b0;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pend;
  logic        any;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  bit mon = 1'b0;

  pri_enc16_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (en),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .pend  (pend),
    .any   (any),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  bit m_reqq[16];
  bit m_pend[16];
  int m_code  = 0;
  bit m_valid = 0;
  bit m_ovf   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_reqq[i] = 0;
        m_pend[i] = 0;
      end
      m_code = 0; m_valid = 0; m_ovf = 0;
    end else begin
      int  acked;
      int  top;
      bit  np[16];
      acked = (m_valid && ack) ? m_code : -1;
      m_ovf = 0;
      top = -1;
      for (int i = 15; i >= 0; i--)
        if (m_pend[i] && top < 0) top = i;
      for (int i = 0; i < 16; i++) begin
        bit ev;
        ev = en && req[i] && !m_reqq[i];
        if (ev && m_pend[i] && i != acked) m_ovf = 1;
        np[i] = (m_pend[i] && i != acked) || ev;
      end
      if (!m_valid) begin
        if (en && top >= 0) begin
          m_valid = 1;
          m_code  = top;
        end
      end else if (ack) begin
        m_valid = 0;
      end
      for (int i = 0; i < 16; i++) begin
        m_pend[i] = np[i];
        m_reqq[i] = req[i];
      end
    end
  end

  function automatic logic [15:0] m_pvec();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon) begin
      chk("mdl_valid", int'(valid), int'(m_valid));
      chk("mdl_code",  int'(code),  m_code);
      chk("mdl_pend",  int'(pend),  int'(m_pvec()));
      chk("mdl_any",   int'(any),   int'(m_pvec() != 16'h0));
      chk("mdl_ovf",   int'(ovf),   int'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input logic v, input logic [3:0] c,
                     input logic [15:0] p, input logic o);
    chk({nm, "_valid"}, int'(valid), int'(v));
    chk({nm, "_code"},  int'(code),  int'(c));
    chk({nm, "_pend"},  int'(pend),  int'(p));
    chk({nm, "_any"},   int'(any),   int'(p != 16'h0));
    chk({nm, "_ovf"},   int'(ovf),   int'(o));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 lit("reset", 0, 0, 16'h0000, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon = 1'b1;
    en = 1'b1;

    // single request
    req = 16'h0004;
    step(1); lit("r29_e1", 0, 0, 16'h0004, 0);
    step(1); lit("r29_e2", 1, 2, 16'h0004, 0);
    ack = 1'b1;
    step(1); lit("r29_ack", 0, 2, 16'h0000, 0);
    ack = 1'b0;

    // two simultaneous rises, top first then one idle gap
    req = 16'h0000; step(1);
    req = 16'h8001;
    step(1); lit("r30_p", 0, 2, 16'h8001, 0);
    step(1); lit("r30_g1", 1, 15, 16'h8001, 0);
    ack = 1'b1;
    step(1); lit("r30_gap", 0, 15, 16'h0001, 0);
    ack = 1'b0;
    step(1); lit("r30_g2", 1, 0, 16'h0001, 0);
    ack = 1'b1;
    step(1); lit("r30_done", 0, 0, 16'h0000, 0);
    ack = 1'b0;

    // higher-priority arrival during a grant
    req = 16'h0000; step(1);
    req = 16'h0008; step(2);
    lit("r31_g3", 1, 3, 16'h0008, 0);
    req = 16'h0208;
    step(1); lit("r31_hold", 1, 3, 16'h0208, 0);
    step(1); lit("r31_hold2", 1, 3, 16'h0208, 0);
    ack = 1'b1;
    step(1); lit("r31_ack", 0, 3, 16'h0200, 0);
    ack = 1'b0;
    step(1); lit("r31_g9", 1, 9, 16'h0200, 0);
    ack = 1'b1; step(1); ack = 1'b0;

    // disabled capture
    req = 16'h0000; step(1);
    en = 1'b0; req = 16'h00F0;
    step(1); lit("r32_off", 0, 9, 16'h0000, 0);
    step(1);
    en = 1'b1;
    step(1); lit("r32_on", 0, 9, 16'h0000, 0);
    step(1); lit("r32_on2", 0, 9, 16'h0000, 0);

    // overflow and set-wins-over-clear
    req = 16'h0000; step(1);
    req = 16'h0020;
    step(1); lit("r33_p", 0, 9, 16'h0020, 0);
    req = 16'h0000;
    step(1); lit("r33_g", 1, 5, 16'h0020, 0);
    req = 16'h0020;
    step(1); lit("r33_ovf", 1, 5, 16'h0020, 1);
    step(1); lit("r33_ovf0", 1, 5, 16'h0020, 0);
    req = 16'h0000; step(1);
    req = 16'h0020; ack = 1'b1;
    step(1); lit("r33_setwin", 0, 5, 16'h0020, 0);
    ack = 1'b0;
    step(1); lit("r33_regrant", 1, 5, 16'h0020, 0);

    // asynchronous reset mid-grant, req held through release
    rst_n = 1'b0;
    #1 lit("r34_rst", 0, 0, 16'h0000, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1); lit("r34_p", 0, 0, 16'h0020, 0);
    step(1); lit("r34_g", 1, 5, 16'h0020, 0);
    ack = 1'b1; step(1); ack = 1'b0;

    // mixed pattern priority
    req = 16'h0000; step(1);
    req = 16'h1234;
    step(2); lit("mix_g", 1, 12, 16'h1234, 0);
    ack = 1'b1; step(1); ack = 1'b0;
    step(1); lit("mix_g2", 1, 9, 16'h0234, 0);
    step(2);

    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_enc16_4.md
PRI_ENC16_4 -- requirements
Module: pri_enc16_4

Interface
REQ-001 Parameters SHALL be none; widths are fixed at 16 request lines and a 4-bit code.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  16  request lines; a 0->1 transition on req[i] raises one event.
REQ-005 en  input  1  enable; gates event capture and new grants.
REQ-006 ack  input  1  consumer acknowledge of the current grant.
REQ-007 code  output  4  binary index of the granted request.
REQ-008 valid  output  1  code is valid and held.
REQ-009 pend  output  16  pending-event register.
REQ-010 any  output  1  OR-reduction of pend (combinational).
REQ-011 ovf  output  1  one-cycle pulse: an event hit a bit already pending.

Function
REQ-012 req_q SHALL register req every cycle; rise[i] = req[i] & ~req_q[i].
REQ-013 On each edge, pend SHALL update as (pend & ~clr) | (rise & {16{en}}), where clr is the one-hot of code when valid & ack, else 0.
REQ-014 Simultaneous rise and clr on the same bit SHALL leave that bit set (set wins).
REQ-015 ovf SHALL be 1 for the cycle after an edge where en & rise[i] & pend[i] & ~clr[i] for any i, else 0.
REQ-016 Priority SHALL be highest index first (bit 15 highest, bit 0 lowest).
REQ-017 The FSM SHALL have 2 states: IDLE (valid=0) and GRANT (valid=1).
REQ-018 IDLE -> GRANT when en=1 and pend != 0; code loads the highest set index of pend on that same edge.
REQ-019 GRANT -> IDLE on an edge with ack=1; the granted pend bit clears on that edge per REQ-013.
REQ-020 In GRANT, code SHALL stay stable, even if a higher-priority event arrives or en falls.
REQ-021 ack SHALL be ignored in IDLE.
REQ-022 Back-to-back grants SHALL be separated by exactly one IDLE cycle (valid low for one cycle).
REQ-023 Latency: an event sampled at edge k sets pend after edge k; with en=1 and the FSM in IDLE, valid rises after edge k+1.
REQ-024 When en=0: no new pend bits are set, no IDLE->GRANT transition occurs, and existing pend bits are retained.
REQ-025 In IDLE, code SHALL hold its last granted value.

Reset
REQ-026 rst_n=0 SHALL immediately force pend=0, req_q=0, code=0, valid=0, ovf=0, and state IDLE, regardless of clk.
REQ-027 A req bit already high at reset release SHALL count as a rising edge on the first active edge.
REQ-028 Reset during GRANT SHALL abandon the grant with no residual pend bit.

Verification
REQ-029 req=16'h0004 from 0 (en=1): pend=0004 after edge 1; valid=1, code=2 after edge 2; ack=1 for one cycle -> valid=0, pend=0.
REQ-030 req=16'h8001 rise together: code=15 first; ack -> 1 IDLE cycle -> code=0, valid=1; ack -> pend=0, any=0.
REQ-031 During a grant with code=3, req[9] rises: code remains 3 until ack; then the next grant gives code=9.
REQ-032 en=0, req=16'h00F0 rises: pend stays 0 and valid stays 0; en=1 without a new edge: still no grant.
REQ-033 pend[5]=1 and req[5] re-rises: ovf=1 for exactly one cycle, pend unchanged; a rise on the acked bit in the ack cycle leaves pend[5]=1.
REQ-034 rst_n driven low mid-GRANT between edges: valid=0, code=0, pend=0 immediately; req held high through release -> pend set after the first edge.
